// File: rtl/mvm_result_packer_pkg.sv
// Shared widths, output payload type and the lane requantizer for the MVM result packer.
package mvm_result_packer_pkg;

  localparam int unsigned P_IWIDTH     = 8;
  localparam int unsigned P_OWIDTH     = 32;
  localparam int unsigned P_NUM_OLANES = 8;
  localparam int unsigned P_MEM_DATAW  = P_IWIDTH * P_NUM_OLANES;
  localparam int unsigned P_VEC_ADDRW  = 8;
  localparam int unsigned P_FIFO_DEPTH = 4;
  localparam int unsigned P_SHIFTW     = 5;

  // One extra bit so the rounding add can never wrap.
  localparam int unsigned P_REQW = P_OWIDTH + 1;

  typedef logic signed [P_OWIDTH-1:0] lane_t;
  typedef logic signed [P_REQW-1:0]   req_t;
  typedef logic [P_IWIDTH-1:0]        qlane_t;

  // Buffered output word: write address plus packed lane data.
  typedef struct packed {
    logic [P_VEC_ADDRW-1:0] addr;
    logic [P_MEM_DATAW-1:0] data;
  } wword_t;

  localparam req_t SAT_MAX = req_t'((2 ** (P_IWIDTH - 1)) - 1);
  localparam req_t SAT_MIN = -SAT_MAX - req_t'(1);

  // Round-half-up arithmetic shift, optional ReLU, then saturate to a signed lane.
  function automatic qlane_t sat_requant(input lane_t x, input logic [P_SHIFTW-1:0] shift,
                                         input logic relu);
    req_t ext;
    req_t rnd;
    req_t y;
    ext = req_t'(x);
    rnd = (shift != '0) ? (req_t'(1) << (shift - P_SHIFTW'(1))) : '0;
    y   = (ext + rnd) >>> shift;
    if (relu && y[P_REQW-1]) begin
      y = '0;
    end
    if (y > SAT_MAX) begin
      return SAT_MAX[P_IWIDTH-1:0];
    end
    if (y < SAT_MIN) begin
      return SAT_MIN[P_IWIDTH-1:0];
    end
    return y[P_IWIDTH-1:0];
  endfunction

endpackage

// File: rtl/mvm_res_fifo.sv
// Synchronous show-ahead FIFO; head entry is visible whenever the FIFO is non-empty.
module mvm_res_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 72
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = PTRW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTRW-1:0]  wr_ptr;
  logic [PTRW-1:0]  rd_ptr;
  logic [CNTW-1:0]  count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNTW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally at a power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTRW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTRW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/mvm_result_packer.sv
// Requantizes one MVM result set per i_valid, packs it into a memory word and
// buffers it for a valid/ready vector-memory write port. The MVM cannot stall,
// so overruns drop the newest word and raise a sticky overflow flag.
// Lane arithmetic and the payload struct come from the package, so the lane
// width parameters are expected to keep their package defaults.
module mvm_result_packer
  import mvm_result_packer_pkg::*;
#(
  parameter int unsigned IWIDTH     = P_IWIDTH,
  parameter int unsigned OWIDTH     = P_OWIDTH,
  parameter int unsigned NUM_OLANES = P_NUM_OLANES,
  parameter int unsigned MEM_DATAW  = IWIDTH * NUM_OLANES,
  parameter int unsigned VEC_ADDRW  = P_VEC_ADDRW,
  parameter int unsigned FIFO_DEPTH = P_FIFO_DEPTH,
  parameter int unsigned SHIFTW     = P_SHIFTW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_cfg_load,
  input  logic [SHIFTW-1:0]        i_shift,
  input  logic                     i_relu,
  input  logic [VEC_ADDRW-1:0]     i_base_addr,
  input  logic                     i_valid,
  input  logic signed [OWIDTH-1:0] i_result [0:NUM_OLANES-1],
  output logic [MEM_DATAW-1:0]     o_wdata,
  output logic [VEC_ADDRW-1:0]     o_waddr,
  output logic                     o_wvalid,
  input  logic                     i_wready,
  output logic                     o_busy,
  output logic                     o_overflow
);

  logic [SHIFTW-1:0]    cfg_shift;
  logic                 cfg_relu;
  logic [VEC_ADDRW-1:0] cfg_base;
  logic [VEC_ADDRW-1:0] word_cnt;
  logic                 s1_valid;
  logic [MEM_DATAW-1:0] s1_data;
  logic                 overflow;
  logic [MEM_DATAW-1:0] packed_c;
  logic                 cfg_ok;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  wword_t               fifo_in;
  wword_t               fifo_out;

  // Per-lane requantization straight off the MVM outputs.
  for (genvar k = 0; k < NUM_OLANES; k++) begin : g_lane
    assign packed_c[k*IWIDTH +: IWIDTH] = IWIDTH'(sat_requant(i_result[k], cfg_shift, cfg_relu));
  end

  assign cfg_ok    = i_cfg_load & ~o_busy & ~i_valid;
  assign fifo_pop  = ~fifo_empty & i_wready;
  assign fifo_push = s1_valid & (~fifo_full | fifo_pop);
  assign fifo_in   = '{addr: cfg_base + word_cnt, data: s1_data};

  mvm_res_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(wword_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_in),
    .pop   (fifo_pop),
    .rdata (fifo_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign o_wdata    = fifo_out.data;
  assign o_waddr    = fifo_out.addr;
  assign o_wvalid   = ~fifo_empty;
  assign o_busy     = s1_valid | ~fifo_empty;
  assign o_overflow = overflow;

  // Config, word counter, stage-1 capture and overflow tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_shift <= '0;
      cfg_relu  <= 1'b0;
      cfg_base  <= '0;
      word_cnt  <= '0;
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      overflow  <= 1'b0;
    end else begin
      if (cfg_ok) begin
        cfg_shift <= i_shift;
        cfg_relu  <= i_relu;
        cfg_base  <= i_base_addr;
        word_cnt  <= '0;
        overflow  <= 1'b0;
      end else if (fifo_push) begin
        word_cnt <= word_cnt + VEC_ADDRW'(1);
      end

      // S1 acts as a one-word skid: it holds when the FIFO cannot take it,
      // and a new result set arriving then is the one that gets dropped.
      if (i_valid) begin
        if (!s1_valid || fifo_push) begin
          s1_valid <= 1'b1;
          s1_data  <= packed_c;
        end else begin
          overflow <= 1'b1;
        end
      end else if (fifo_push) begin
        s1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mvm_result_packer.sv
// Directed bench for mvm_result_packer with a queue-based output scoreboard.
module tb_mvm_result_packer;

  logic              clk;
  logic              rst;
  logic              i_cfg_load;
  logic [4:0]        i_shift;
  logic              i_relu;
  logic [7:0]        i_base_addr;
  logic              i_valid;
  logic signed [31:0] i_result [0:7];
  logic [63:0]       o_wdata;
  logic [7:0]        o_waddr;
  logic              o_wvalid;
  logic              i_wready;
  logic              o_busy;
  logic              o_overflow;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  addr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mvm_result_packer dut (
    .clk         (clk),
    .rst         (rst),
    .i_cfg_load  (i_cfg_load),
    .i_shift     (i_shift),
    .i_relu      (i_relu),
    .i_base_addr (i_base_addr),
    .i_valid     (i_valid),
    .i_result    (i_result),
    .o_wdata     (o_wdata),
    .o_waddr     (o_waddr),
    .o_wvalid    (o_wvalid),
    .i_wready    (i_wready),
    .o_busy      (o_busy),
    .o_overflow  (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int l0, input int l1, input int l2, input int l3,
                       input int l4, input int l5, input int l6, input int l7,
                       input logic [63:0] d, input logic [7:0] a, input bit keep);
    exp_t e;
    i_valid     = 1'b1;
    i_result[0] = 32'(l0);
    i_result[1] = 32'(l1);
    i_result[2] = 32'(l2);
    i_result[3] = 32'(l3);
    i_result[4] = 32'(l4);
    i_result[5] = 32'(l5);
    i_result[6] = 32'(l6);
    i_result[7] = 32'(l7);
    if (keep) begin
      e.data = d;
      e.addr = a;
      sb.push_back(e);
    end
    tick();
  endtask

  task automatic issue_all(input int v, input logic [63:0] d, input logic [7:0] a, input bit keep);
    issue(v, v, v, v, v, v, v, v, d, a, keep);
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic cfg(input logic [4:0] sh, input logic relu, input logic [7:0] base);
    i_cfg_load  = 1'b1;
    i_shift     = sh;
    i_relu      = relu;
    i_base_addr = base;
    tick();
    i_cfg_load  = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((sb.size() != 0 || o_busy) && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(sb.size()), 64'd0);
  endtask

  // Pops the oldest expected word whenever a transfer is about to happen.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && o_wvalid && i_wready) begin
        if (sb.size() == 0) begin
          check("unexpected_word", {56'd0, o_waddr}, 64'hDEAD);
        end else begin
          e = sb.pop_front();
          check("wdata", o_wdata, e.data);
          check("waddr", {56'd0, o_waddr}, {56'd0, e.addr});
        end
      end
    end
  endtask

  initial begin
    logic [7:0] b;
    rst         = 1'b1;
    i_cfg_load  = 1'b0;
    i_shift     = '0;
    i_relu      = 1'b0;
    i_base_addr = '0;
    i_valid     = 1'b0;
    i_wready    = 1'b1;
    for (int k = 0; k < 8; k++) i_result[k] = '0;
    fork
      monitor();
    join_none

    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_wvalid", {63'd0, o_wvalid}, 64'd0);
    check("rst_busy", {63'd0, o_busy}, 64'd0);
    check("rst_overflow", {63'd0, o_overflow}, 64'd0);
    check("rst_wdata", o_wdata, 64'd0);
    check("rst_waddr", {56'd0, o_waddr}, 64'd0);

    // Packing and two-cycle latency.
    cfg(5'd0, 1'b0, 8'h10);
    issue(-4, -3, -2, -1, 0, 1, 2, 3, 64'h03020100FFFEFDFC, 8'h10, 1'b1);
    i_valid = 1'b0;
    @(negedge clk);
    check("lat_wvalid_e", {63'd0, o_wvalid}, 64'd0);
    check("lat_busy_e", {63'd0, o_busy}, 64'd1);
    tick();
    @(negedge clk);
    check("lat_wvalid_e1", {63'd0, o_wvalid}, 64'd1);
    idle(3);

    // Saturation without and with ReLU.
    cfg(5'd0, 1'b0, 8'h20);
    issue(1000, -1000, 127, -129, -5, 0, 0, 0, 64'h000000FB807F807F, 8'h20, 1'b1);
    idle(3);
    cfg(5'd0, 1'b1, 8'h30);
    issue(1000, -1000, 127, -129, -5, 0, 0, 0, 64'h00000000007F007F, 8'h30, 1'b1);
    idle(3);

    // Rounding shift, back-to-back sets.
    cfg(5'd2, 1'b0, 8'h40);
    issue(6, -6, 5, -2, 10, -7, 1000, -3, 64'hFF7FFE030001FF02, 8'h40, 1'b1);
    issue_all(4, 64'h0101010101010101, 8'h41, 1'b1);
    idle(4);
    wait_drain("drain_basic", 20);

    // Backpressure: four in FIFO, one held in S1, sixth dropped.
    cfg(5'd0, 1'b0, 8'h50);
    i_wready = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      b = 8'(j);
      issue_all(j, {8{b}}, 8'(8'h50 + j - 1), j <= 5);
      if (j == 5) begin
        @(negedge clk);
        check("ovf_before", {63'd0, o_overflow}, 64'd0);
      end
    end
    @(negedge clk);
    check("ovf_after", {63'd0, o_overflow}, 64'd1);
    i_valid = 1'b0;
    tick();
    @(negedge clk);
    check("stall_wdata", o_wdata, 64'h0101010101010101);
    check("stall_waddr", {56'd0, o_waddr}, 64'h50);
    tick();
    tick();
    @(negedge clk);
    check("stall_hold", o_wdata, 64'h0101010101010101);
    check("stall_busy", {63'd0, o_busy}, 64'd1);
    tick();
    i_wready = 1'b1;
    wait_drain("drain_bp", 30);
    check("ovf_sticky", {63'd0, o_overflow}, 64'd1);

    // Address wrap; config load also clears overflow.
    cfg(5'd0, 1'b0, 8'hFE);
    @(negedge clk);
    check("ovf_cleared", {63'd0, o_overflow}, 64'd0);
    for (int j = 0; j < 4; j++) begin
      b = 8'(16 * (j + 1));
      issue_all(16 * (j + 1), {8{b}}, 8'(254 + j), 1'b1);
    end
    idle(2);
    wait_drain("drain_wrap", 20);

    // Reset with words queued, then a config load while busy is ignored.
    i_wready = 1'b0;
    issue_all(3, 64'h0303030303030303, 8'h00, 1'b0);
    issue_all(3, 64'h0303030303030303, 8'h00, 1'b0);
    issue_all(3, 64'h0303030303030303, 8'h00, 1'b0);
    idle(3);
    @(negedge clk);
    check("queued_wvalid", {63'd0, o_wvalid}, 64'd1);
    check("queued_busy", {63'd0, o_busy}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("flush_wvalid", {63'd0, o_wvalid}, 64'd0);
    check("flush_busy", {63'd0, o_busy}, 64'd0);
    check("flush_wdata", o_wdata, 64'd0);
    tick();
    i_wready = 1'b1;
    issue_all(7, 64'h0707070707070707, 8'h00, 1'b1);
    i_valid     = 1'b0;
    i_cfg_load  = 1'b1;
    i_base_addr = 8'h99;
    i_shift     = 5'd3;
    i_relu      = 1'b1;
    tick();
    i_cfg_load = 1'b0;
    idle(3);
    issue_all(9, 64'h0909090909090909, 8'h01, 1'b1);
    idle(3);
    wait_drain("drain_final", 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
